// File: rtl/matmul_result_writer_pkg.sv
// Shared defaults, FSM encoding and address helpers for matmul_result_writer.
// The READ state exists only when MATMUL_ACC_EN is defined.
package matmul_result_writer_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int BUS_WIDTH_DEF   = 16;
  localparam int SP_NTARGETS_DEF = 4;
  localparam int MAX_DIM_DEF     = BUS_WIDTH_DEF / DATA_WIDTH_DEF;
  localparam int DIM_W           = 2;

`ifdef MATMUL_ACC_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd3
  } state_e;
`endif

  // The multiplier delivers C column-major; the scratchpad stores it row-major.
  function automatic int elem_index(input int row, input int col, input int max_dim);
    return col * max_dim + row;
  endfunction

  function automatic int slot_addr(input int tgt, input int row, input int col, input int max_dim);
    return tgt * max_dim * max_dim + row * max_dim + col;
  endfunction

endpackage

// File: rtl/matmul_elem_sel.sv
// Combinational pick of one result element and its overflow flag from the
// captured column-major matrix.
module matmul_elem_sel
  import matmul_result_writer_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int MAX_DIM   = MAX_DIM_DEF,
  parameter int IDX_W     = 2
) (
  input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] matrix_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]           flags_i,
  input  logic [DIM_W-1:0]                     row_i,
  input  logic [DIM_W-1:0]                     col_i,
  output logic [IDX_W-1:0]                     idx_o,
  output logic signed [BUS_WIDTH-1:0]          elem_o,
  output logic                                 flag_o
);

  always_comb begin
    idx_o  = IDX_W'(elem_index(int'(row_i), int'(col_i), MAX_DIM));
    elem_o = matrix_i[idx_o*BUS_WIDTH +: BUS_WIDTH];
    flag_o = flags_i[idx_o];
  end

endmodule

// File: rtl/matmul_result_writer.sv
// Writes the multiplier's C matrix into a scratchpad slot, row-major.
// Define MATMUL_ACC_EN to add read-modify-write accumulation with overflow flags.
module matmul_result_writer
  import matmul_result_writer_pkg::*;
#(
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int BUS_WIDTH   = BUS_WIDTH_DEF,
  parameter  int SP_NTARGETS = SP_NTARGETS_DEF,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int ELEMS       = MAX_DIM * MAX_DIM,
  localparam int ADDR_W      = $clog2(SP_NTARGETS * ELEMS),
  localparam int TGT_W       = $clog2(SP_NTARGETS),
  localparam int IDX_W       = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       finish_mul_i,
  input  logic [ELEMS*BUS_WIDTH-1:0] c_matrix_i,
  input  logic [ELEMS-1:0]           flags_i,
  input  logic [DIM_W-1:0]           n_dim_i,
  input  logic [DIM_W-1:0]           m_dim_i,
  input  logic [TGT_W-1:0]           sp_target_i,
  input  logic                       mode_bit_i,
  output logic                       sp_wr_en_o,
  output logic                       sp_rd_en_o,
  output logic [ADDR_W-1:0]          sp_addr_o,
  output logic [BUS_WIDTH-1:0]       sp_wdata_o,
  input  logic [BUS_WIDTH-1:0]       sp_rdata_i,
  output logic [ELEMS-1:0]           flags_o,
  output logic                       finish_write_o,
  output logic                       busy_o
);

  state_e                     state_q;
  logic [ELEMS*BUS_WIDTH-1:0] mat_q;
  logic [DIM_W-1:0]           n_q, m_q, row_q, col_q;
  logic [TGT_W-1:0]           tgt_q;
  logic [IDX_W-1:0]           idx;
  logic signed [BUS_WIDTH-1:0] elem;
  logic                       elem_flag;
  logic [BUS_WIDTH-1:0]       wdata;
  logic                       last_elem;
  logic                       wr, rd;

  // Dimensions beyond the array size would index outside the captured matrix.
  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
    return (int'(d) > MAX_DIM - 1) ? DIM_W'(MAX_DIM - 1) : d;
  endfunction

  matmul_elem_sel #(
    .BUS_WIDTH (BUS_WIDTH),
    .MAX_DIM   (MAX_DIM),
    .IDX_W     (IDX_W)
  ) u_elem_sel (
    .matrix_i (mat_q),
    .flags_i  (flags_o),
    .row_i    (row_q),
    .col_i    (col_q),
    .idx_o    (idx),
    .elem_o   (elem),
    .flag_o   (elem_flag)
  );

  assign last_elem = (row_q == n_q) && (col_q == m_q);

`ifdef MATMUL_ACC_EN
  logic                 acc_q;
  logic [BUS_WIDTH-1:0] sum;
  logic                 ovf;

  always_comb begin
    sum   = sp_rdata_i + elem;
    ovf   = (sp_rdata_i[BUS_WIDTH-1] == elem[BUS_WIDTH-1]) &&
            (sum[BUS_WIDTH-1] != elem[BUS_WIDTH-1]);
    wdata = acc_q ? sum : elem;
  end
  assign rd = (state_q == ST_READ);
`else
  logic unused_ok;
  assign unused_ok = ^{sp_rdata_i, mode_bit_i, elem_flag, idx};
  assign wdata     = elem;
  assign rd        = 1'b0;
`endif

  assign wr = (state_q == ST_WRITE);

  always_comb begin
    // NOTE: every output gets a default before any condition so no latch is inferred.
    sp_wr_en_o     = wr;
    sp_rd_en_o     = rd;
    sp_addr_o      = '0;
    sp_wdata_o     = '0;
    finish_write_o = (state_q == ST_DONE) && finish_mul_i;
    busy_o         = (state_q != ST_IDLE);
    if (wr || rd) sp_addr_o = ADDR_W'(slot_addr(int'(tgt_q), int'(row_q), int'(col_q), MAX_DIM));
    if (wr)       sp_wdata_o = wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the captured matrix is ordinary flops, not a RAM, so it is reset too.
      state_q <= ST_IDLE;
      mat_q   <= '0;
      flags_o <= '0;
      n_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tgt_q   <= '0;
`ifdef MATMUL_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (finish_mul_i) begin
            mat_q   <= c_matrix_i;
            flags_o <= flags_i;
            n_q     <= clamp_dim(n_dim_i);
            m_q     <= clamp_dim(m_dim_i);
            tgt_q   <= sp_target_i;
            row_q   <= '0;
            col_q   <= '0;
`ifdef MATMUL_ACC_EN
            acc_q   <= mode_bit_i;
            state_q <= mode_bit_i ? ST_READ : ST_WRITE;
`else
            state_q <= ST_WRITE;
`endif
          end
        end
`ifdef MATMUL_ACC_EN
        ST_READ: state_q <= ST_WRITE;
`endif
        ST_WRITE: begin
`ifdef MATMUL_ACC_EN
          if (acc_q) flags_o[idx] <= elem_flag | ovf;
`endif
          if (last_elem) begin
            state_q <= ST_DONE;
          end else begin
            if (col_q == m_q) begin
              col_q <= '0;
              row_q <= row_q + DIM_W'(1);
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
`ifdef MATMUL_ACC_EN
            state_q <= acc_q ? ST_READ : ST_WRITE;
`else
            state_q <= ST_WRITE;
`endif
          end
        end
        ST_DONE: if (!finish_mul_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_result_writer.sv
// Directed bench for matmul_result_writer with a small scratchpad RAM model.
// Accumulate vectors run only when MATMUL_ACC_EN is defined.
module tb_matmul_result_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        finish_mul = 1'b0;
  logic [63:0] c_matrix = '0;
  logic [3:0]  flags_in = '0;
  logic [1:0]  n_dim = '0, m_dim = '0, tgt = '0;
  logic        mode = 1'b0;
  logic        wr_en, rd_en, fin_wr, busy;
  logic [3:0]  addr, flags_out;
  logic [15:0] wdata;
  logic [15:0] rdata = '0;

  logic [15:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          wr_count = 0;
  int          overlap_cnt = 0;
  int          idle_bad = 0;
  int          checks = 0;
  int          failures = 0;
  int          wc0;

  always #5 clk = ~clk;

  matmul_result_writer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .finish_mul_i   (finish_mul),
    .c_matrix_i     (c_matrix),
    .flags_i        (flags_in),
    .n_dim_i        (n_dim),
    .m_dim_i        (m_dim),
    .sp_target_i    (tgt),
    .mode_bit_i     (mode),
    .sp_wr_en_o     (wr_en),
    .sp_rd_en_o     (rd_en),
    .sp_addr_o      (addr),
    .sp_wdata_o     (wdata),
    .sp_rdata_i     (rdata),
    .flags_o        (flags_out),
    .finish_write_o (fin_wr),
    .busy_o         (busy)
  );

  // Scratchpad model: synchronous write, read data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (wr_en) begin
      mem[addr] <= wdata;
      wr_count  <= wr_count + 1;
    end
    if (rd_en) rdata <= mem[addr];
  end

  always @(negedge clk) begin
    if (wr_en && rd_en) overlap_cnt++;
    if (!wr_en && !rd_en && (addr != 4'd0 || wdata != 16'd0)) idle_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] t, input logic [1:0] n, input logic [1:0] m,
                           input logic [63:0] mat, input logic [3:0] f, input logic md);
    tgt = t; n_dim = n; m_dim = m; c_matrix = mat; flags_in = f; mode = md;
    finish_mul = 1'b1;
    @(negedge clk);
  endtask

  task automatic expect_write(input string tag, input logic [3:0] a, input logic [15:0] d);
    check({tag, "_wr"},   {31'd0, wr_en}, 32'd1);
    check({tag, "_rd"},   {31'd0, rd_en}, 32'd0);
    check({tag, "_addr"}, {28'd0, addr},  {28'd0, a});
    check({tag, "_data"}, {16'd0, wdata}, {16'd0, d});
    @(negedge clk);
  endtask

  task automatic expect_read(input string tag, input logic [3:0] a);
    check({tag, "_rd"},   {31'd0, rd_en}, 32'd1);
    check({tag, "_wr"},   {31'd0, wr_en}, 32'd0);
    check({tag, "_addr"}, {28'd0, addr},  {28'd0, a});
    @(negedge clk);
  endtask

  task automatic handshake(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_fin"},  {31'd0, fin_wr}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy},   32'd1);
      @(negedge clk);
    end
    finish_mul = 1'b0;
    #1;
    check({tag, "_fin_drop"}, {31'd0, fin_wr}, 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1;
    check("rst_wr",    {31'd0, wr_en},     32'd0);
    check("rst_rd",    {31'd0, rd_en},     32'd0);
    check("rst_addr",  {28'd0, addr},      32'd0);
    check("rst_data",  {16'd0, wdata},     32'd0);
    check("rst_flags", {28'd0, flags_out}, 32'd0);
    check("rst_fin",   {31'd0, fin_wr},    32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2 into slot 2, C = [[1,-2],[3,4]] column-major; inputs scrambled after capture
    start_job(2'd2, 2'd1, 2'd1, {16'd4, 16'hFFFE, 16'd3, 16'd1}, 4'b0101, 1'b0);
    c_matrix = 64'hDEAD_BEEF_0BAD_F00D; n_dim = 2'd0; m_dim = 2'd0;
    tgt = 2'd0; flags_in = 4'b1010; mode = 1'b1;
    check("t1_flags", {28'd0, flags_out}, 32'h5);
    expect_write("t1_e0", 4'd8,  16'h0001);
    expect_write("t1_e1", 4'd9,  16'hFFFE);
    expect_write("t1_e2", 4'd10, 16'h0003);
    expect_write("t1_e3", 4'd11, 16'h0004);
    check("t1_done_wr", {31'd0, wr_en}, 32'd0);
    handshake("t1", 3);
    check("t1_mem", {mem[8], mem[9]}, 32'h0001_FFFE);
    check("t1_mem2", {mem[10], mem[11]}, 32'h0003_0004);
    check("t1_flags_held", {28'd0, flags_out}, 32'h5);

    // single row, two columns into slot 0; addresses 2 and 3 must stay untouched
    preload(4'd2, 16'hA5A5);
    preload(4'd3, 16'hA5A5);
    wc0 = wr_count;
    start_job(2'd0, 2'd0, 2'd1, {16'h0044, 16'h0022, 16'h0033, 16'h0011}, 4'b0000, 1'b0);
    expect_write("t2_e0", 4'd0, 16'h0011);
    expect_write("t2_e1", 4'd1, 16'h0022);
    handshake("t2", 1);
    check("t2_count", wr_count - wc0, 32'd2);
    check("t2_untouched", {mem[2], mem[3]}, 32'hA5A5_A5A5);

    // reset after the second write, then a fresh job restarts at element 0
    preload(4'd6, 16'h5A5A);
    preload(4'd7, 16'h5A5A);
    wc0 = wr_count;
    start_job(2'd1, 2'd1, 2'd1, {16'h000D, 16'h000C, 16'h000B, 16'h000A}, 4'b1111, 1'b0);
    expect_write("t3_e0", 4'd4, 16'h000A);
    expect_write("t3_e1", 4'd5, 16'h000C);
    rst_n = 1'b0;
    #1;
    check("t3_rst_wr",    {31'd0, wr_en},     32'd0);
    check("t3_rst_addr",  {28'd0, addr},      32'd0);
    check("t3_rst_data",  {16'd0, wdata},     32'd0);
    check("t3_rst_busy",  {31'd0, busy},      32'd0);
    check("t3_rst_flags", {28'd0, flags_out}, 32'd0);
    repeat (3) @(negedge clk);
    check("t3_count", wr_count - wc0, 32'd2);
    check("t3_partial", {mem[6], mem[7]}, 32'h5A5A_5A5A);
    rst_n = 1'b1;
    @(negedge clk);
    expect_write("t3_r0", 4'd4, 16'h000A);
    expect_write("t3_r1", 4'd5, 16'h000C);
    expect_write("t3_r2", 4'd6, 16'h000B);
    expect_write("t3_r3", 4'd7, 16'h000D);
    handshake("t3", 1);
    check("t3_mem", {mem[6], mem[7]}, 32'h000B_000D);

`ifdef MATMUL_ACC_EN
    // accumulate into slot 3; elements (0,0) and (1,1) overflow
    preload(4'd12, 16'h7FFF);
    preload(4'd13, 16'h0001);
    preload(4'd14, 16'hFFFF);
    preload(4'd15, 16'h8000);
    start_job(2'd3, 2'd1, 2'd1, {16'hFFFF, 16'hFFFE, 16'h0001, 16'h0001}, 4'b0000, 1'b1);
    expect_read ("t4_r0", 4'd12);
    expect_write("t4_w0", 4'd12, 16'h8000);
    expect_read ("t4_r1", 4'd13);
    expect_write("t4_w1", 4'd13, 16'hFFFF);
    expect_read ("t4_r2", 4'd14);
    expect_write("t4_w2", 4'd14, 16'h0000);
    expect_read ("t4_r3", 4'd15);
    expect_write("t4_w3", 4'd15, 16'h7FFF);
    handshake("t4", 1);
    check("t4_flags", {28'd0, flags_out}, 32'h9);
`endif

    check("no_overlap", overlap_cnt, 32'd0);
    check("idle_zero",  idle_bad,    32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
